tx_ring_writer_arb: RTL and testbench

Write-side scheduler for the 512-qword TX frame ring drained by the TX MAC interface. Two frame sources (host DMA channels) request the ring; the block picks one round-robin, reserves ring space against `commited_rd_addr`, writes a header qword plus the frame payload into the ring memory, and then publishes the frame by advancing `commited_wr_addr`. The MAC side never sees a partially written frame.

---
 rtl/tx_ring_pkg.sv | 26 ++
 rtl/tx_ring_writer_arb_rr_arb2.sv | 25 ++
 rtl/tx_ring_writer_arb.sv | 151 +++++++++++++++
 tb/tb_tx_ring_writer_arb.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_ring_pkg.sv
// Shared constants, FSM encoding and header helpers for the TX ring writer.
package tx_ring_pkg;

  localparam int RING_QWORDS = 512;
  localparam int MAX_BYTES   = 4088;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HDR,
    ST_DATA,
    ST_COMMIT
  } state_t;

  // Header qword: byte count in the upper word, lower word reserved as zero.
  function automatic logic [63:0] make_hdr(input logic [12:0] bytes);
    return {19'b0, bytes, 32'b0};
  endfunction

  function automatic logic [10:0] qwords_of(input logic [12:0] bytes);
    logic [13:0] rounded;
    rounded = {1'b0, bytes} + 14'd7;
    return rounded[13:3];
  endfunction

endpackage

// File: rtl/tx_ring_writer_arb_rr_arb2.sv
// Two-request round-robin arbiter; priority flips away from the served port on each strobe.
module rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic strobe,
  input  logic served,
  output logic win
);

  logic rr;

  // A lone requester wins outright; rr only breaks ties.
  always_comb begin
    if (req0 && req1) win = rr;
    else              win = req1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rr <= 1'b0;
    else if (strobe) rr <= ~served;
  end

endmodule

// File: rtl/tx_ring_writer_arb.sv
// Write-side scheduler for the TX frame ring: arbitrates two frame sources, writes
// header and payload into ring memory, then publishes the frame via commited_wr_addr.
module tx_ring_writer_arb
  import tx_ring_pkg::state_t, tx_ring_pkg::ST_IDLE, tx_ring_pkg::ST_CHECK,
         tx_ring_pkg::ST_HDR, tx_ring_pkg::ST_DATA, tx_ring_pkg::ST_COMMIT,
         tx_ring_pkg::make_hdr, tx_ring_pkg::qwords_of;
#(
  parameter int RING_AW   = 9,
  parameter int MAX_BYTES = 4088
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [12:0]        bytes0,
  input  logic [12:0]        bytes1,
  output logic               grant0,
  output logic               grant1,
  input  logic [63:0]        data0,
  input  logic [63:0]        data1,
  input  logic               valid0,
  input  logic               valid1,
  output logic               done0,
  output logic               done1,
  output logic               err0,
  output logic               err1,
  output logic [RING_AW-1:0] wr_addr,
  output logic [63:0]        wr_data,
  output logic               wr_en,
  output logic [RING_AW:0]   commited_wr_addr,
  input  logic [RING_AW:0]   commited_rd_addr
);

  localparam int SW = RING_AW + 2;
  localparam logic [RING_AW:0] PTR_ONE = 1;

  state_t             state;
  logic               cur_port;
  logic [12:0]        cur_bytes;
  logic [10:0]        cnt;
  logic [RING_AW:0]   wr_ptr;
  logic [RING_AW:0]   used;
  logic [SW-1:0]      need;
  logic               illegal;
  logic               space_ok;
  logic               req0_eff;
  logic               req1_eff;
  logic               win;
  logic               arb_strobe;
  logic               valid_sel;
  logic [63:0]        data_sel;

  // A rejected source still holds req during the err cycle; mask it so it is not re-latched.
  assign req0_eff = req0 & ~err0;
  assign req1_eff = req1 & ~err1;

  assign illegal  = (cur_bytes == 13'd0) || (cur_bytes > 13'(MAX_BYTES));
  assign used     = wr_ptr - commited_rd_addr;
  assign need     = SW'(qwords_of(cur_bytes)) + SW'(1);
  assign space_ok = (SW'(used) + need) <= SW'(1 << RING_AW);

  assign arb_strobe = (state == ST_CHECK) && (illegal || space_ok);
  assign valid_sel  = cur_port ? valid1 : valid0;
  assign data_sel   = cur_port ? data1 : data0;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0_eff),
    .req1    (req1_eff),
    .strobe  (arb_strobe),
    .served  (cur_port),
    .win     (win)
  );

  // Outputs are registered on the transition, so the header write and grant are
  // visible during the HDR cycle itself and the source may start payload next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      cur_port         <= 1'b0;
      cur_bytes        <= '0;
      cnt              <= '0;
      wr_ptr           <= '0;
      grant0           <= 1'b0;
      grant1           <= 1'b0;
      done0            <= 1'b0;
      done1            <= 1'b0;
      err0             <= 1'b0;
      err1             <= 1'b0;
      wr_en            <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
      commited_wr_addr <= '0;
    end else begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      wr_en  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0_eff || req1_eff) begin
            cur_port  <= win;
            cur_bytes <= win ? bytes1 : bytes0;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (illegal) begin
            err0  <= ~cur_port;
            err1  <= cur_port;
            state <= ST_IDLE;
          end else if (space_ok) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_ptr[RING_AW-1:0];
            wr_data <= make_hdr(cur_bytes);
            grant0  <= ~cur_port;
            grant1  <= cur_port;
            wr_ptr  <= wr_ptr + PTR_ONE;
            cnt     <= qwords_of(cur_bytes);
            state   <= ST_HDR;
          end
        end
        ST_HDR: begin
          state <= ST_DATA;
        end
        ST_DATA: begin
          if (valid_sel) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_ptr[RING_AW-1:0];
            wr_data <= data_sel;
            wr_ptr  <= wr_ptr + PTR_ONE;
            cnt     <= cnt - 11'd1;
            if (cnt == 11'd1) state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          commited_wr_addr <= wr_ptr;
          done0            <= ~cur_port;
          done1            <= cur_port;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ring_writer_arb.sv
// Self-checking bench for tx_ring_writer_arb: scenario tasks plus randomized frames
// checked against a ring-address model of header/payload placement and commits.
module tb_tx_ring_writer_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [12:0] bytes0 = '0, bytes1 = '0;
  logic [63:0] data0 = '0, data1 = '0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic [9:0]  commited_rd_addr = '0;
  logic        grant0, grant1, done0, done1, err0, err1, wr_en;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  commited_wr_addr;

  tx_ring_writer_arb dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req0             (req0),
    .req1             (req1),
    .bytes0           (bytes0),
    .bytes1           (bytes1),
    .grant0           (grant0),
    .grant1           (grant1),
    .data0            (data0),
    .data1            (data1),
    .valid0           (valid0),
    .valid1           (valid1),
    .done0            (done0),
    .done1            (done1),
    .err0             (err0),
    .err1             (err1),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_en            (wr_en),
    .commited_wr_addr (commited_wr_addr),
    .commited_rd_addr (commited_rd_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;
  int model_wptr = 0;
  int exp_addr[$], obs_addr[$], obs_cyc[$], gnt_q[$];
  logic [63:0] exp_data[$], obs_data[$];
  int err_cnt0 = 0, err_cnt1 = 0;

  // Passive monitor of the ring write port and arbiter pulses.
  always @(negedge clk) begin
    if (wr_en) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(wr_data);
      obs_cyc.push_back(cyc);
    end
    if (grant0) gnt_q.push_back(0);
    if (grant1) gnt_q.push_back(1);
    if (err0) err_cnt0++;
    if (err1) err_cnt1++;
  end

  task automatic clear_obs;
    exp_addr.delete(); exp_data.delete();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); gnt_q.delete();
  endtask

  task automatic do_reset(input bit both);
    @(posedge clk); #1;
    reset_n = 1'b0; valid0 = 0; valid1 = 0;
    req0 = both; req1 = both; bytes0 = 13'd17; bytes1 = 13'd17;
    commited_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_wptr = 0;
    clear_obs();
  endtask

  // Drives one frame from a source; the expected ring image comes from plain address arithmetic.
  task automatic drive_frame(input int port, input int nbytes, input bit gaps,
                             output bit ok, output int rcyc, output int gcyc, output int dcyc);
    int nq, base, k;
    bit got, phase;
    logic [63:0] d;
    nq = (nbytes + 7) / 8;
    base = model_wptr;
    ok = 1'b1; gcyc = -1; dcyc = -1;
    exp_addr.push_back(base % 512);
    exp_data.push_back(64'(nbytes) << 32);
    @(posedge clk); #1;
    rcyc = cyc;
    if (port == 0) begin req0 = 1; bytes0 = 13'(nbytes); end
    else begin req1 = 1; bytes1 = 13'(nbytes); end
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if ((port == 0 && grant0) || (port == 1 && grant1)) begin got = 1; gcyc = cyc; end
    end
    @(posedge clk); #1;
    if (port == 0) req0 = 0; else req1 = 0;
    if (!got) begin ok = 0; return; end
    k = 0; phase = 0;
    while (k < nq) begin
      if (gaps && phase) begin
        if (port == 0) valid0 = 0; else valid1 = 0;
      end else begin
        d = {$urandom, $urandom};
        if (port == 0) begin valid0 = 1; data0 = d; end else begin valid1 = 1; data1 = d; end
        exp_addr.push_back((base + 1 + k) % 512);
        exp_data.push_back(d);
        k++;
      end
      phase = ~phase;
      if (port == 0) begin valid1 = 1'($urandom_range(0, 1)); data1 = {$urandom, $urandom}; end
      else begin valid0 = 1'($urandom_range(0, 1)); data0 = {$urandom, $urandom}; end
      @(posedge clk); #1;
    end
    valid0 = 0; valid1 = 0;
    for (int i = 0; i < 50 && dcyc < 0; i++) begin
      @(negedge clk);
      if ((port == 0 && done0) || (port == 1 && done1)) dcyc = cyc;
    end
    if (dcyc < 0) ok = 0;
    model_wptr = (base + 1 + nq) % 1024;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({grant0, grant1, done0, done1, err0, err1, wr_en} !== 7'b0) begin
      n_fail++; $display("[TB] FAIL reset_pulses: got %b want 0000000", {grant0, grant1, done0, done1, err0, err1, wr_en});
    end
    n_cmp++;
    if (wr_addr !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    n_cmp++;
    if (wr_data !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_wr_data: got %h want 0", wr_data); end
    n_cmp++;
    if (commited_wr_addr !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_commit: got %0d want 0", commited_wr_addr); end
    @(posedge clk); #1 reset_n = 1'b1;
    model_wptr = 0;
    clear_obs();
  endtask

  task automatic test_single;
    bit ok; int r, g, d;
    drive_frame(0, 64, 0, ok, r, g, d);
    n_cmp++;
    if (!ok) begin n_fail++; $display("[TB] FAIL single_handshake: got timeout want grant+done"); end
    n_cmp++;
    if (g !== r + 2) begin n_fail++; $display("[TB] FAIL single_grant_lat: got %0d want %0d", g - r, 2); end
    n_cmp++;
    if (commited_wr_addr !== 10'd9) begin n_fail++; $display("[TB] FAIL single_commit: got %0d want 9", commited_wr_addr); end
    n_cmp++;
    if (obs_addr.size() !== exp_addr.size()) begin
      n_fail++; $display("[TB] FAIL single_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("[TB] FAIL single_wr%0d: got @%0d %h want @%0d %h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    if (obs_cyc.size() == 9) begin
      n_cmp++;
      if (obs_cyc[0] !== g || obs_cyc[1] !== g + 2) begin
        n_fail++; $display("[TB] FAIL single_wr_timing: got hdr %0d pay %0d want %0d %0d", obs_cyc[0], obs_cyc[1], g, g + 2);
      end
      n_cmp++;
      if (d !== obs_cyc[8] + 1) begin n_fail++; $display("[TB] FAIL single_done_lat: got %0d want %0d", d, obs_cyc[8] + 1); end
    end
  endtask

  task automatic test_contention;
    bit ok; int r, g, d;
    do_reset(1'b1);
    drive_frame(0, 17, 0, ok, r, g, d);
    n_cmp++;
    if (!ok || commited_wr_addr !== 10'd4) begin
      n_fail++; $display("[TB] FAIL cont_first_commit: got ok=%0d commit=%0d want ok=1 commit=4", ok, commited_wr_addr);
    end
    drive_frame(1, 17, 0, ok, r, g, d);
    n_cmp++;
    if (!ok || commited_wr_addr !== 10'd8) begin
      n_fail++; $display("[TB] FAIL cont_second_commit: got ok=%0d commit=%0d want ok=1 commit=8", ok, commited_wr_addr);
    end
    @(posedge clk); #1;
    req0 = 1; req1 = 1; bytes0 = 13'd17; bytes1 = 13'd17;
    drive_frame(0, 17, 0, ok, r, g, d);
    drive_frame(1, 17, 0, ok, r, g, d);
    n_cmp++;
    if (gnt_q.size() !== 4 || gnt_q[0] !== 0 || gnt_q[1] !== 1 || gnt_q[2] !== 0 || gnt_q[3] !== 1) begin
      n_fail++; $display("[TB] FAIL cont_order: got %p want '{0,1,0,1}", gnt_q);
    end
    n_cmp++;
    if (obs_addr.size() !== exp_addr.size()) begin
      n_fail++; $display("[TB] FAIL cont_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("[TB] FAIL cont_wr%0d: got @%0d %h want @%0d %h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_full_ring;
    bit ok; int r, g, d, rel;
    do_reset(1'b0);
    for (int f = 0; f < 4; f++) drive_frame(0, 992, 0, ok, r, g, d);
    n_cmp++;
    if (commited_wr_addr !== 10'd500) begin n_fail++; $display("[TB] FAIL full_fill: got %0d want 500", commited_wr_addr); end
    clear_obs();
    rel = -1;
    fork
      drive_frame(1, 120, 0, ok, r, g, d);
      begin
        repeat (20) @(posedge clk);
        n_cmp++;
        if (obs_addr.size() !== 0 || gnt_q.size() !== 0) begin
          n_fail++; $display("[TB] FAIL full_stall: got %0d writes %0d grants want 0 0", obs_addr.size(), gnt_q.size());
        end
        #1 commited_rd_addr = 10'd4;
        rel = cyc;
      end
    join
    n_cmp++;
    if (!ok || obs_cyc.size() == 0 || obs_cyc[0] !== rel + 1) begin
      n_fail++; $display("[TB] FAIL full_release_lat: got ok=%0d hdr_cyc=%0d want %0d", ok, obs_cyc.size() ? obs_cyc[0] : -1, rel + 1);
    end
    n_cmp++;
    if (commited_wr_addr !== 10'd516) begin n_fail++; $display("[TB] FAIL full_commit: got %0d want 516", commited_wr_addr); end
    n_cmp++;
    if (obs_addr.size() !== exp_addr.size()) begin
      n_fail++; $display("[TB] FAIL full_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("[TB] FAIL full_wr%0d: got @%0d %h want @%0d %h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_illegal;
    bit ok, seen; int r, g, d, e0;
    int bad_len[2] = '{0, 4089};
    commited_rd_addr = 10'(model_wptr);
    for (int t = 0; t < 2; t++) begin
      clear_obs();
      e0 = err_cnt0;
      @(posedge clk); #1;
      req0 = 1; bytes0 = 13'(bad_len[t]);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (err0) seen = 1; end
      @(posedge clk); #1 req0 = 0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (!seen || err_cnt0 - e0 !== 1) begin
        n_fail++; $display("[TB] FAIL illegal_err_%0d: got %0d pulses want 1", bad_len[t], err_cnt0 - e0);
      end
      n_cmp++;
      if (obs_addr.size() !== 0 || gnt_q.size() !== 0) begin
        n_fail++; $display("[TB] FAIL illegal_quiet_%0d: got %0d writes %0d grants want 0 0", bad_len[t], obs_addr.size(), gnt_q.size());
      end
      n_cmp++;
      if (commited_wr_addr !== 10'(model_wptr)) begin
        n_fail++; $display("[TB] FAIL illegal_commit_%0d: got %0d want %0d", bad_len[t], commited_wr_addr, model_wptr);
      end
    end
    clear_obs();
    @(posedge clk); #1;
    req0 = 1; req1 = 1; bytes0 = 13'd8; bytes1 = 13'd8;
    drive_frame(1, 8, 0, ok, r, g, d);
    drive_frame(0, 8, 0, ok, r, g, d);
    n_cmp++;
    if (gnt_q.size() !== 2 || gnt_q[0] !== 1 || gnt_q[1] !== 0) begin
      n_fail++; $display("[TB] FAIL illegal_rr: got %p want '{1,0}", gnt_q);
    end
    n_cmp++;
    if (commited_wr_addr !== 10'(model_wptr)) begin
      n_fail++; $display("[TB] FAIL illegal_rr_commit: got %0d want %0d", commited_wr_addr, model_wptr);
    end
  endtask

  task automatic test_gaps;
    bit ok; int r, g, d;
    clear_obs();
    commited_rd_addr = 10'(model_wptr);
    drive_frame(1, 24, 1, ok, r, g, d);
    n_cmp++;
    if (!ok || obs_addr.size() !== 4) begin
      n_fail++; $display("[TB] FAIL gaps_count: got ok=%0d writes=%0d want ok=1 writes=4", ok, obs_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        n_fail++; $display("[TB] FAIL gaps_wr%0d: got @%0d %h want @%0d %h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    if (obs_cyc.size() == 4) begin
      n_cmp++;
      if (obs_cyc[3] !== g + 6 || d !== g + 7) begin
        n_fail++; $display("[TB] FAIL gaps_timing: got last_wr=%0d done=%0d want %0d %0d", obs_cyc[3], d, g + 6, g + 7);
      end
    end
    n_cmp++;
    if (commited_wr_addr !== 10'(model_wptr)) begin
      n_fail++; $display("[TB] FAIL gaps_commit: got %0d want %0d", commited_wr_addr, model_wptr);
    end
  endtask

  task automatic test_reset_mid_data;
    bit ok, seen; int r, g, d;
    clear_obs();
    commited_rd_addr = 10'(model_wptr);
    @(posedge clk); #1;
    req0 = 1; bytes0 = 13'd64;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (grant0) seen = 1; end
    @(posedge clk); #1;
    req0 = 0; valid0 = 1; data0 = {$urandom, $urandom};
    @(posedge clk); #1 data0 = {$urandom, $urandom};
    @(posedge clk); #1 valid0 = 0;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (!seen || obs_addr.size() !== 3) begin
      n_fail++; $display("[TB] FAIL midrst_prewrites: got grant=%0d writes=%0d want 1 3", seen, obs_addr.size());
    end
    n_cmp++;
    if ({grant0, grant1, done0, done1, err0, err1, wr_en} !== 7'b0 || wr_addr !== 9'd0 || wr_data !== 64'd0) begin
      n_fail++; $display("[TB] FAIL midrst_outputs: got %b addr=%0d data=%h want 0", {grant0, grant1, done0, done1, err0, err1, wr_en}, wr_addr, wr_data);
    end
    n_cmp++;
    if (commited_wr_addr !== 10'd0) begin n_fail++; $display("[TB] FAIL midrst_commit: got %0d want 0", commited_wr_addr); end
    @(posedge clk); #1;
    commited_rd_addr = '0;
    reset_n = 1'b1;
    model_wptr = 0;
    clear_obs();
    drive_frame(0, 16, 0, ok, r, g, d);
    n_cmp++;
    if (!ok || obs_addr.size() !== 3 || obs_addr[0] !== 0 || commited_wr_addr !== 10'd3) begin
      n_fail++; $display("[TB] FAIL midrst_restart: got ok=%0d writes=%0d commit=%0d want 1 3 3", ok, obs_addr.size(), commited_wr_addr);
    end
  endtask

  task automatic test_random;
    bit ok; int r, g, d, port, nbytes, need, used;
    for (int f = 0; f < 12; f++) begin
      clear_obs();
      port = $urandom_range(0, 1);
      if (f == 0) nbytes = 4088;
      else if ($urandom_range(0, 3) == 0) nbytes = $urandom_range(1, 4088);
      else nbytes = $urandom_range(1, 80);
      need = 1 + (nbytes + 7) / 8;
      used = $urandom_range(0, 512 - need);
      commited_rd_addr = 10'((model_wptr - used + 1024) % 1024);
      drive_frame(port, nbytes, 1'($urandom_range(0, 1)), ok, r, g, d);
      n_cmp++;
      if (!ok || commited_wr_addr !== 10'(model_wptr)) begin
        n_fail++; $display("[TB] FAIL rand%0d_commit: got ok=%0d commit=%0d want %0d", f, ok, commited_wr_addr, model_wptr);
      end
      n_cmp++;
      if (obs_addr.size() !== exp_addr.size()) begin
        n_fail++; $display("[TB] FAIL rand%0d_count: got %0d writes want %0d", f, obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_fail++; $display("[TB] FAIL rand%0d_wr%0d: got @%0d %h want @%0d %h", f, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full_ring();
    test_illegal();
    test_gaps();
    test_reset_mid_data();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
